// File: rtl/ann_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ann_pkg
//  Brief    : Shared types and default sizes for the ANN coefficient loader.
//  Revision : 1.0 - initial release
// ============================================================================
package ann_pkg;

    localparam int IMAGE_SIZE  = 64;
    localparam int FIRST_LAYER = 16;
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 20;
    localparam int WEIGHT_BASE = 'h10000;
    localparam int TIMEOUT     = 255;

    typedef enum logic [1:0] {
        SEL_IMG  = 2'd0,
        SEL_WGT  = 2'd1,
        SEL_BOTH = 2'd2,
        SEL_RSVD = 2'd3
    } coef_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } loader_state_t;

    typedef enum logic {
        PH_IMG = 1'b0,
        PH_WGT = 1'b1
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/coef_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : coef_bank
//  Brief    : Write-indexed register array exposed as one flat bus.
//  Revision : 1.0 - initial release
// ============================================================================
module coef_bank #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 16,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [DATA_W-1:0]         wr_data,
    output logic [DEPTH*DATA_W-1:0]   data_o
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [DATA_W-1:0] word_d;
        logic [DATA_W-1:0] word_q;

        always_comb begin
            word_d = word_q;
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                word_d = wr_data;
            end
        end

        always_ff @(posedge clk) begin
            if (!n_reset) begin
                word_q <= '0;
            end else begin
                word_q <= word_d;
            end
        end

        assign data_o[i*DATA_W +: DATA_W] = word_q;
    end

endmodule
`default_nettype wire

// File: rtl/coef_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : coef_loader
//  Brief    : Fetches an image and/or first-layer weights word by word into
//             local banks and pulses loaded on completion.
//  Revision : 1.0 - initial release
// ============================================================================
module coef_loader #(
    parameter int                IMAGE_SIZE  = ann_pkg::IMAGE_SIZE,
    parameter int                FIRST_LAYER = ann_pkg::FIRST_LAYER,
    parameter int                DATA_W      = ann_pkg::DATA_W,
    parameter int                ADDR_W      = ann_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] WEIGHT_BASE = ADDR_W'(ann_pkg::WEIGHT_BASE),
    parameter int                TIMEOUT     = ann_pkg::TIMEOUT
) (
    input  logic                                     clk,
    input  logic                                     n_reset,
    input  logic                                     request_coef,
    input  logic [1:0]                               coef_select,
    input  logic [9:0]                               image_address,
    output logic                                     rd_en,
    output logic [ADDR_W-1:0]                        rd_addr,
    input  logic [DATA_W-1:0]                        rd_data,
    input  logic                                     rd_valid,
    output logic [IMAGE_SIZE*DATA_W-1:0]             image_o,
    output logic [FIRST_LAYER*IMAGE_SIZE*DATA_W-1:0] weights_o,
    output logic                                     busy,
    output logic                                     loaded,
    output logic                                     error
);
    import ann_pkg::*;

    localparam int C_WGT_WORDS = FIRST_LAYER * IMAGE_SIZE;
    localparam int C_IMG_IDX_W = $clog2(IMAGE_SIZE);
    localparam int C_WGT_IDX_W = $clog2(C_WGT_WORDS);
    localparam int C_IDX_W     = (C_WGT_IDX_W > C_IMG_IDX_W) ? C_WGT_IDX_W : C_IMG_IDX_W;
    localparam int C_TMO_W     = $clog2(TIMEOUT + 1);

    localparam logic [C_IDX_W-1:0] C_IMG_LAST = C_IDX_W'(IMAGE_SIZE - 1);
    localparam logic [C_IDX_W-1:0] C_WGT_LAST = C_IDX_W'(C_WGT_WORDS - 1);
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT - 1);

    loader_state_t       state_d,    state_q;
    coef_sel_t           sel_d,      sel_q;
    phase_t              phase_d,    phase_q;
    logic [9:0]          img_addr_d, img_addr_q;
    logic [C_IDX_W-1:0]  idx_d,      idx_q;
    logic [C_TMO_W-1:0]  tmo_d,      tmo_q;
    logic                error_d,    error_q;
    logic                rd_en_d,    rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_d,  rd_addr_q;
    logic                busy_d,     busy_q;
    logic                loaded_d,   loaded_q;

    logic                w_img_we;
    logic                w_wgt_we;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        phase_d    = phase_q;
        img_addr_d = img_addr_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        error_d    = error_q;
        rd_addr_d  = rd_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (request_coef && (coef_sel_t'(coef_select) != SEL_RSVD)) begin
                    state_d    = ST_REQ;
                    sel_d      = coef_sel_t'(coef_select);
                    img_addr_d = image_address;
                    error_d    = 1'b0;
                    phase_d    = (coef_sel_t'(coef_select) == SEL_WGT) ? PH_WGT : PH_IMG;
                    idx_d      = '0;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
                tmo_d   = '0;
            end
            ST_WAIT: begin
                if (rd_valid) begin
                    if ((phase_q == PH_IMG) && (idx_q == C_IMG_LAST)) begin
                        if (sel_q == SEL_BOTH) begin
                            phase_d = PH_WGT;
                            idx_d   = '0;
                            state_d = ST_REQ;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else if ((phase_q == PH_WGT) && (idx_q == C_WGT_LAST)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_REQ;
                    end
                end else if (tmo_q == C_TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they line up with it.
        rd_en_d  = (state_d == ST_REQ);
        busy_d   = (state_d != ST_IDLE);
        loaded_d = (state_d == ST_DONE);
        if (state_d == ST_REQ) begin
            rd_addr_d = (phase_d == PH_IMG)
                      ? (ADDR_W'(img_addr_d) << C_IMG_IDX_W) + ADDR_W'(idx_d)
                      : WEIGHT_BASE + ADDR_W'(idx_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_IMG;
            phase_q    <= PH_IMG;
            img_addr_q <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            error_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            phase_q    <= phase_d;
            img_addr_q <= img_addr_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            error_q    <= error_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            loaded_q   <= loaded_d;
        end
    end

    assign w_img_we = (state_q == ST_WAIT) && rd_valid && (phase_q == PH_IMG);
    assign w_wgt_we = (state_q == ST_WAIT) && rd_valid && (phase_q == PH_WGT);

    coef_bank #(
        .DEPTH  (IMAGE_SIZE),
        .DATA_W (DATA_W),
        .IDX_W  (C_IMG_IDX_W)
    ) u_img_bank (
        .clk     (clk),
        .n_reset (n_reset),
        .wr_en   (w_img_we),
        .wr_idx  (idx_q[C_IMG_IDX_W-1:0]),
        .wr_data (rd_data),
        .data_o  (image_o)
    );

    coef_bank #(
        .DEPTH  (C_WGT_WORDS),
        .DATA_W (DATA_W),
        .IDX_W  (C_WGT_IDX_W)
    ) u_wgt_bank (
        .clk     (clk),
        .n_reset (n_reset),
        .wr_en   (w_wgt_we),
        .wr_idx  (idx_q[C_WGT_IDX_W-1:0]),
        .wr_data (rd_data),
        .data_o  (weights_o)
    );

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign loaded  = loaded_q;
    assign error   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_coef_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_coef_loader
//  Brief    : Self-checking bench for coef_loader with a latency memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_coef_loader;

    localparam int IS = 64;
    localparam int FL = 16;
    localparam int DW = 16;
    localparam int AW = 20;
    localparam int NW = FL * IS;

    logic              clk = 1'b0;
    logic              n_reset = 1'b0;
    logic              request_coef = 1'b0;
    logic [1:0]        coef_select = 2'd0;
    logic [9:0]        image_address = 10'd0;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data = '0;
    logic              rd_valid = 1'b0;
    logic [IS*DW-1:0]  image_o;
    logic [NW*DW-1:0]  weights_o;
    logic              busy;
    logic              loaded;
    logic              error;

    coef_loader dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .request_coef  (request_coef),
        .coef_select   (coef_select),
        .image_address (image_address),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .image_o       (image_o),
        .weights_o     (weights_o),
        .busy          (busy),
        .loaded        (loaded),
        .error         (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory: answers each rd_en after mem_lat cycles with addr[15:0]^mem_key.
    int            mem_lat  = 1;
    logic [15:0]   mem_key  = 16'hA5A5;
    bit            drop_en  = 1'b0;
    logic [AW-1:0] drop_addr = '0;
    bit            mem_spur = 1'b0;
    bit            spur_req = 1'b0;
    bit            pend = 1'b0;
    int            cnt = 0;
    logic [AW-1:0] paddr = '0;

    always @(posedge clk) begin
        #1;
        rd_valid = 1'b0;
        if (pend) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                pend     = 1'b0;
                rd_valid = 1'b1;
                rd_data  = paddr[15:0] ^ mem_key;
            end
        end
        if (mem_spur) begin
            rd_valid = 1'b1;
            rd_data  = 16'hDEAD;
        end
        if (rd_en) begin
            if (spur_req) begin
                rd_valid = 1'b1;
                rd_data  = 16'hDEAD;
            end
            if (!(drop_en && rd_addr == drop_addr)) begin
                pend  = 1'b1;
                cnt   = mem_lat;
                paddr = rd_addr;
            end
        end
    end

    int            n_busy = 0;
    int            n_loaded = 0;
    int            loaded_at = 0;
    logic [AW-1:0] addr_log[$];

    always @(negedge clk) begin
        if (busy) n_busy++;
        if (loaded) begin
            n_loaded++;
            loaded_at = n_busy;
        end
        if (rd_en) addr_log.push_back(rd_addr);
    end

    logic [IS*DW-1:0] exp_img = '0;
    logic [NW*DW-1:0] exp_wgt = '0;

    task automatic model_img(input logic [9:0] ia, input logic [15:0] key, input int n);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = (AW'(ia) << 6) + AW'(i);
            exp_img[i*DW +: DW] = a[15:0] ^ key;
        end
    endtask

    task automatic model_wgt(input logic [15:0] key);
        logic [AW-1:0] a;
        for (int j = 0; j < NW; j++) begin
            a = 20'h10000 + AW'(j);
            exp_wgt[j*DW +: DW] = a[15:0] ^ key;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_img(input string name);
        int bad = -1;
        checks++;
        for (int i = 0; i < IS; i++)
            if (bad < 0 && image_o[i*DW +: DW] !== exp_img[i*DW +: DW]) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: image word %0d got %h expected %h", name, bad,
                     image_o[bad*DW +: DW], exp_img[bad*DW +: DW]);
        end
    endtask

    task automatic check_wgt(input string name);
        int bad = -1;
        checks++;
        for (int i = 0; i < NW; i++)
            if (bad < 0 && weights_o[i*DW +: DW] !== exp_wgt[i*DW +: DW]) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: weight word %0d got %h expected %h", name, bad,
                     weights_o[bad*DW +: DW], exp_wgt[bad*DW +: DW]);
        end
    endtask

    task automatic do_request(input logic [1:0] sel, input logic [9:0] ia);
        @(negedge clk);
        coef_select   = sel;
        image_address = ia;
        request_coef  = 1'b1;
        @(negedge clk);
        request_coef  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        check({name, "_idle"}, busy, 0);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [9:0]  ia;
        int          lat;
        logic [15:0] key;
        int          exp_busy;
        int          exp_reads;
        logic [19:0] exp_first;
        logic [19:0] exp_last;
        int          img_idx;
        logic [15:0] img_val;
        int          wgt_idx;
        logic [15:0] wgt_val;
    } vec_t;

    vec_t vecs[4];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int b0;
        int l0;
        int a0;

        vecs[0] = '{2'd0, 10'd3,    1, 16'hA5A5,  129,   64, 20'h000C0, 20'h000FF,  5, 16'hA560, 1023, 16'h0000};
        vecs[1] = '{2'd1, 10'd0,    2, 16'hA5A5, 3073, 1024, 20'h10000, 20'h103FF,  5, 16'hA560, 1023, 16'hA65A};
        vecs[2] = '{2'd2, 10'd5,    3, 16'h5A5A, 4353, 1088, 20'h00140, 20'h103FF, 63, 16'h5B25, 1023, 16'h59A5};
        vecs[3] = '{2'd0, 10'd1023, 1, 16'h1234,  129,   64, 20'h0FFC0, 20'h0FFFF,  0, 16'hEDF4, 1023, 16'h59A5};

        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_loaded", loaded, 0);
        check("rst_error", error, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check_img("rst_image");
        check_wgt("rst_weights");
        n_reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            mem_lat = vecs[v].lat;
            mem_key = vecs[v].key;
            b0 = n_busy; l0 = n_loaded; a0 = addr_log.size();
            do_request(vecs[v].sel, vecs[v].ia);
            wait_idle($sformatf("v%0d", v), 6000);
            if (vecs[v].sel != 2'd1) model_img(vecs[v].ia, vecs[v].key, IS);
            if (vecs[v].sel != 2'd0) model_wgt(vecs[v].key);
            check($sformatf("v%0d_busy_cycles", v), n_busy - b0, vecs[v].exp_busy);
            check($sformatf("v%0d_loaded_count", v), n_loaded - l0, 1);
            check($sformatf("v%0d_loaded_cycle", v), loaded_at - b0, vecs[v].exp_busy);
            check($sformatf("v%0d_error", v), error, 0);
            check($sformatf("v%0d_reads", v), addr_log.size() - a0, vecs[v].exp_reads);
            if (addr_log.size() > a0) begin
                check($sformatf("v%0d_first_addr", v), addr_log[a0], vecs[v].exp_first);
                check($sformatf("v%0d_last_addr", v), addr_log[addr_log.size()-1], vecs[v].exp_last);
            end
            check($sformatf("v%0d_img_word", v), image_o[vecs[v].img_idx*DW +: DW], vecs[v].img_val);
            check($sformatf("v%0d_wgt_word", v), weights_o[vecs[v].wgt_idx*DW +: DW], vecs[v].wgt_val);
            check_img($sformatf("v%0d_image", v));
            check_wgt($sformatf("v%0d_weights", v));
        end

        // Timeout on image word 10 (address 0x8A).
        mem_lat = 1; mem_key = 16'h0F0F; drop_en = 1'b1; drop_addr = 20'h0008A;
        b0 = n_busy; l0 = n_loaded; a0 = addr_log.size();
        do_request(2'd0, 10'd2);
        wait_idle("tmo", 400);
        drop_en = 1'b0;
        model_img(10'd2, 16'h0F0F, 10);
        check("tmo_error", error, 1);
        check("tmo_no_loaded", n_loaded - l0, 0);
        check("tmo_busy_cycles", n_busy - b0, 276);
        check("tmo_reads", addr_log.size() - a0, 11);
        check_img("tmo_image");

        // Reserved select: ignored, error stays set.
        a0 = addr_log.size();
        do_request(2'd3, 10'd5);
        repeat (3) @(negedge clk);
        #1;
        check("rsvd_error_kept", error, 1);
        check("rsvd_busy", busy, 0);
        check("rsvd_reads", addr_log.size() - a0, 0);

        // Request held high across a load: one load only, error cleared.
        @(negedge clk);
        mem_key = 16'h7777;
        b0 = n_busy; l0 = n_loaded; a0 = addr_log.size();
        coef_select = 2'd0; image_address = 10'd7; request_coef = 1'b1;
        @(negedge clk);
        #1;
        check("held_error_cleared", error, 0);
        check("held_busy", busy, 1);
        repeat (48) @(negedge clk);
        request_coef = 1'b0;
        wait_idle("held", 400);
        repeat (5) @(negedge clk);
        #1;
        model_img(10'd7, 16'h7777, IS);
        check("held_loaded_count", n_loaded - l0, 1);
        check("held_busy_cycles", n_busy - b0, 129);
        check("held_reads", addr_log.size() - a0, 64);
        check_img("held_image");

        // Reset in the middle of weight word 500.
        mem_key = 16'hC3C3;
        a0 = addr_log.size();
        do_request(2'd1, 10'd0);
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            #1;
            if (addr_log.size() >= a0 + 501) break;
        end
        check("mid_reset_reached", addr_log.size() - a0, 501);
        n_reset = 1'b0;
        @(negedge clk);
        #1;
        exp_img = '0;
        exp_wgt = '0;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_loaded", loaded, 0);
        check("mid_reset_error", error, 0);
        check_img("mid_reset_image");
        check_wgt("mid_reset_weights");
        n_reset = 1'b1;
        repeat (4) @(negedge clk);
        check_wgt("post_reset_drain_weights");

        mem_key = 16'h3C3C;
        b0 = n_busy; l0 = n_loaded;
        do_request(2'd1, 10'd0);
        wait_idle("fresh", 3000);
        model_wgt(16'h3C3C);
        check("fresh_busy_cycles", n_busy - b0, 2049);
        check("fresh_loaded_count", n_loaded - l0, 1);
        check_wgt("fresh_weights");
        check_img("fresh_image_kept");

        // Spurious rd_valid while idle.
        mem_spur = 1'b1;
        repeat (5) @(negedge clk);
        mem_spur = 1'b0;
        repeat (2) @(negedge clk);
        check_img("spur_idle_image");
        check_wgt("spur_idle_weights");

        // Spurious rd_valid during every REQ cycle, latency 3.
        mem_lat = 3; mem_key = 16'h1111; spur_req = 1'b1;
        b0 = n_busy;
        do_request(2'd0, 10'd4);
        @(negedge clk);
        #1;
        check("spur_req_word0", image_o[0 +: DW], exp_img[0 +: DW]);
        wait_idle("spur_req", 400);
        spur_req = 1'b0;
        model_img(10'd4, 16'h1111, IS);
        check("spur_req_busy_cycles", n_busy - b0, 257);
        check_img("spur_req_image");

        // Back-to-back: second load accepted right after the loaded pulse.
        mem_lat = 1; mem_key = 16'h2222;
        l0 = n_loaded; a0 = addr_log.size();
        @(negedge clk);
        coef_select = 2'd0; image_address = 10'd9; request_coef = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            if (loaded) break;
        end
        check("b2b_first_loaded", loaded, 1);
        @(negedge clk);
        #1;
        check("b2b_gap_busy", busy, 0);
        check("b2b_gap_loaded", loaded, 0);
        @(negedge clk);
        #1;
        check("b2b_second_busy", busy, 1);
        check("b2b_second_rd_en", rd_en, 1);
        check("b2b_second_addr", rd_addr, 20'h00240);
        request_coef = 1'b0;
        wait_idle("b2b", 400);
        model_img(10'd9, 16'h2222, IS);
        check("b2b_loaded_count", n_loaded - l0, 2);
        check("b2b_reads", addr_log.size() - a0, 128);
        check_img("b2b_image");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
